rx_fcs_strip: RTL and testbench
===============================

RX_FCS_STRIP -- requirements
Module: rx_fcs_strip

Sits between the RMII RX byte assembler and the ETH/ARP/IP/UDP parser. Checks Ethernet FCS, strips the 4 FCS bytes and reports per-frame status.

Interface
REQ-001 SHALL have parameter MIN_LEN, default 64, minimum legal frame length in bytes including FCS.
REQ-002 SHALL have parameter MAX_LEN, default 1522, maximum legal frame length in bytes including FCS.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  RMII 50 MHz domain clock; all logic on rising edge.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 sof  in  1  one-cycle pulse, coincident with vld of the first byte after SFD.
REQ-007 vld  in  1  byte_in valid, at most one byte per cycle.
REQ-008 byte_in  in  8  received byte, destination MAC first.
REQ-009 eof  in  1  one-cycle pulse after the last byte; never coincident with vld.
REQ-010 o_sof  out  1  one-cycle pulse, coincident with o_vld of the first stripped byte.
REQ-011 o_vld  out  1  o_byte valid.
REQ-012 o_byte  out  8  frame byte with FCS removed.
REQ-013 o_eof  out  1  one-cycle end-of-frame pulse; status outputs valid in this cycle.
REQ-014 o_fcs_ok  out  1  frame CRC residue correct.
REQ-015 o_len_err  out  1  length below MIN_LEN or above MAX_LEN.
REQ-016 o_abort  out  1  frame terminated by a new sof before eof.
REQ-017 o_len  out  11  stripped length (total minus 4, floored at 0), saturating at 2047.
REQ-018 good_cnt, bad_cnt  out  16 each  frames with (fcs_ok && !len_err && !abort) / otherwise; wrap modulo 2^16.

Function
REQ-019 SHALL hold a 4-byte delay line; each input vld shifts in byte_in, and once 4 bytes are held the oldest byte is emitted.
REQ-020 Emitted byte SHALL appear on o_byte/o_vld one cycle after the input vld that displaced it; o_vld never asserts for the final 4 bytes of a frame.
REQ-021 o_sof SHALL assert with the first emitted byte (the byte shifted out by input byte 5).
REQ-022 CRC-32 SHALL be reflected poly 0xEDB88320, init 0xFFFFFFFF on sof, and updated over every input byte including FCS, LSB first, with no final XOR.
REQ-023 o_fcs_ok SHALL be 1 iff the CRC register equals 0xDEBB20E3 after the last byte.
REQ-024 Total byte counter SHALL be 11 bits, cleared on sof (first byte counts as 1), and saturate at 2047.
REQ-025 State machine SHALL have states IDLE, FILL (fewer than 4 bytes held), STREAM and DONE.
REQ-026 IDLE->FILL on sof&vld; FILL->STREAM on the 4th byte; FILL/STREAM->DONE on eof; DONE->IDLE unconditionally after one cycle.
REQ-027 o_eof SHALL pulse in the cycle after input eof, i.e. in DONE.
REQ-028 vld or eof without a preceding sof SHALL be ignored in IDLE; no outputs.
REQ-029 Frames with total length 4 or less SHALL produce no o_vld/o_sof but SHALL produce o_eof with o_len=0 and o_len_err=1.
REQ-030 sof in FILL/STREAM SHALL produce o_eof next cycle with o_abort=1, o_fcs_ok=0, count bad_cnt, and start the new frame from the coincident byte with no loss.
REQ-031 eof arriving in DONE SHALL be ignored.
REQ-032 Bytes held in the delay line at eof or abort SHALL be discarded.
REQ-033 Status outputs SHALL hold their value until the next o_eof; counters SHALL update in the o_eof cycle.

Reset
REQ-034 rst_n=0 SHALL force IDLE, clear the delay line and CRC, and drive o_sof, o_vld, o_eof, o_fcs_ok, o_len_err and o_abort to 0; o_byte, o_len and both counters SHALL read 0.
REQ-035 Reset mid-frame SHALL drop the frame silently: no o_eof and no counter change.
REQ-036 After reset release, the first accepted event SHALL be the next sof.

Verification
REQ-037 ASCII "123456789" + bytes 26 39 F4 CB (13 bytes), then eof -> 9 bytes "123456789" out, o_fcs_ok=1, o_len=9, o_len_err=1, bad_cnt=1.
REQ-038 64-byte frame with valid FCS, vld every 4th cycle -> 60 o_vld bytes matching input, o_eof with o_fcs_ok=1, o_len=60, good_cnt=1.
REQ-039 Same frame with byte 20 bit-flipped -> o_fcs_ok=0, bad_cnt=1, 60 bytes still emitted.
REQ-040 3-byte frame -> no o_vld, o_eof with o_len=0, o_len_err=1.
REQ-041 sof at byte 30 of a frame, followed by a valid 64-byte frame -> first o_eof with o_abort=1, then second o_eof with o_fcs_ok=1 and good_cnt=1.
REQ-042 rst_n low at byte 40 for 1 cycle, then a valid 64-byte frame -> no o_eof for the dropped frame; good_cnt=1, bad_cnt=0.

Source files
------------

// File: rtl/rx_fcs_strip.sv
// rx_fcs_strip: Ethernet receive FCS checker and stripper.
// Bytes from the RMII byte assembler pass through a 4-byte delay line, so
// the trailing FCS never reaches the parser. A reflected CRC-32 runs over
// every received byte, FCS included. At end of frame the residue, length
// and abort status are reported together with an o_eof pulse, and the
// good/bad frame counters advance.
module rx_fcs_strip #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1522
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sof,
    input  logic        vld,
    input  logic [7:0]  byte_in,
    input  logic        eof,
    output logic        o_sof,
    output logic        o_vld,
    output logic [7:0]  o_byte,
    output logic        o_eof,
    output logic        o_fcs_ok,
    output logic        o_len_err,
    output logic        o_abort,
    output logic [10:0] o_len,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [31:0] MIN_L       = MIN_LEN;
    localparam logic [31:0] MAX_L       = MAX_LEN;
    localparam logic [10:0] CNT_MAX     = 11'h7FF;

    state_t      state;
    state_t      state_nxt;

    logic [7:0]  dly [4];      // dly[0] newest, dly[3] oldest once four bytes are held
    logic [10:0] cnt;          // bytes received in the current frame, saturating
    logic [31:0] crc;

    logic        frame_active;
    logic        start;
    logic        abort;
    logic        take;
    logic        fin;
    logic        close;
    logic        emit;
    logic        len_err_now;
    logic        fcs_ok_now;
    logic        good_now;
    logic [10:0] strip_len;
    logic [31:0] cnt_ext;

    // One byte of the reflected CRC-32, LSB of the data first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    // Byte counter increment that sticks at the top of the 11-bit range.
    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == CNT_MAX) ? v : v + 11'd1;
    endfunction

    // Length after removing the FCS, never negative.
    function automatic logic [10:0] strip4(input logic [10:0] v);
        return (v > 11'd4) ? v - 11'd4 : 11'd0;
    endfunction

    // Decode the input events against the current state.
    always_comb begin
        frame_active = (state == FILL) || (state == STREAM);
        start        = sof && vld && (state != DONE);
        abort        = sof && vld && frame_active;
        take         = vld && !sof && frame_active;
        fin          = eof && !(sof && vld) && frame_active;
        close        = abort || fin;
        emit         = take && (state == STREAM);
        cnt_ext      = {21'd0, cnt};
        len_err_now  = (cnt_ext < MIN_L) || (cnt_ext > MAX_L);
        fcs_ok_now   = fin && (crc == CRC_RESIDUE);
        good_now     = fcs_ok_now && !len_err_now;
        strip_len    = strip4(cnt);
    end

    // Next-state logic: a new sof always restarts, the 4th byte starts streaming.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (sof && vld) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (sof && vld) begin
                    state_nxt = FILL;
                end else if (vld && (cnt == 11'd3)) begin
                    state_nxt = STREAM;
                end else if (eof) begin
                    state_nxt = DONE;
                end
            end
            STREAM: begin
                if (sof && vld) begin
                    state_nxt = FILL;
                end else if (eof) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Delay line, byte counter and CRC; a sof restarts all three from its byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                dly[i] <= 8'd0;
            end
            cnt <= 11'd0;
            crc <= 32'd0;
        end else if (start) begin
            dly[0] <= byte_in;
            cnt    <= 11'd1;
            crc    <= crc_byte(CRC_INIT, byte_in);
        end else if (take) begin
            dly[0] <= byte_in;
            dly[1] <= dly[0];
            dly[2] <= dly[1];
            dly[3] <= dly[2];
            cnt    <= sat_inc(cnt);
            crc    <= crc_byte(crc, byte_in);
        end
    end

    // Stripped byte output: the oldest held byte leaves when a new one arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_vld  <= 1'b0;
            o_sof  <= 1'b0;
            o_byte <= 8'd0;
        end else begin
            o_vld <= 1'b0;
            o_sof <= 1'b0;
            if (emit) begin
                o_vld  <= 1'b1;
                o_byte <= dly[3];
                // Byte 5 of the frame pushes out byte 1.
                o_sof  <= (cnt == 11'd4);
            end
        end
    end

    // Frame status, captured at eof or abort and held until the next frame closes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_eof     <= 1'b0;
            o_fcs_ok  <= 1'b0;
            o_len_err <= 1'b0;
            o_abort   <= 1'b0;
            o_len     <= 11'd0;
        end else begin
            o_eof <= 1'b0;
            if (close) begin
                o_eof     <= 1'b1;
                o_fcs_ok  <= fcs_ok_now;
                o_len_err <= len_err_now;
                o_abort   <= abort;
                o_len     <= strip_len;
            end
        end
    end

    // Good/bad frame counters, advanced together with o_eof.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            good_cnt <= 16'd0;
            bad_cnt  <= 16'd0;
        end else if (close) begin
            if (good_now) begin
                good_cnt <= good_cnt + 16'd1;
            end else begin
                bad_cnt <= bad_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rx_fcs_strip.sv
// Testbench for rx_fcs_strip: stimulus pushes expected bytes and frame
// status into queues; a monitor pops and compares whenever the DUT emits.
module tb_rx_fcs_strip;

    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1522;
    localparam logic [31:0] POLY    = 32'hEDB8_8320;
    localparam logic [31:0] RESIDUE = 32'hDEBB_20E3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sof = 1'b0;
    logic        vld = 1'b0;
    logic        eof = 1'b0;
    logic [7:0]  byte_in = 8'd0;
    logic        o_sof, o_vld, o_eof, o_fcs_ok, o_len_err, o_abort;
    logic [7:0]  o_byte;
    logic [10:0] o_len;
    logic [15:0] good_cnt, bad_cnt;

    always #10 clk = ~clk;

    rx_fcs_strip #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .sof(sof), .vld(vld), .byte_in(byte_in), .eof(eof),
        .o_sof(o_sof), .o_vld(o_vld), .o_byte(o_byte), .o_eof(o_eof),
        .o_fcs_ok(o_fcs_ok), .o_len_err(o_len_err), .o_abort(o_abort), .o_len(o_len),
        .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    typedef struct {
        logic [7:0] b;
        logic       s;
    } exp_byte_t;

    typedef struct {
        logic        ok;
        logic        lerr;
        logic        ab;
        logic [10:0] len;
        logic [15:0] g;
        logic [15:0] bd;
    } exp_stat_t;

    exp_byte_t   bq[$];
    exp_stat_t   sq[$];
    logic [7:0]  frm[$];
    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] m_good = 16'd0;
    logic [15:0] m_bad = 16'd0;
    logic        mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    endtask

    // CRC-32 (reflected, init all ones, no final XOR) over the first n frame bytes.
    function automatic logic [31:0] crc_of(input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, frm[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
        end
        return c;
    endfunction

    // Random payload of n-4 bytes followed by its correct FCS, least significant byte first.
    task automatic build_good(input int n);
        logic [31:0] f;
        frm.delete();
        for (int i = 0; i < n - 4; i++) frm.push_back(8'($urandom));
        f = ~crc_of(n - 4);
        for (int i = 0; i < 4; i++) frm.push_back(f[8*i +: 8]);
    endtask

    task automatic build_rand(input int n);
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
    endtask

    // Reference model: k bytes of frm were delivered, the frame then ended by eof or abort.
    task automatic expect_frame(input int k, input logic aborted);
        exp_stat_t st;
        for (int i = 0; i < k - 4; i++) bq.push_back('{b: frm[i], s: (i == 0)});
        st.ab   = aborted;
        st.ok   = !aborted && (crc_of(k) == RESIDUE);
        st.len  = (k > 4) ? 11'(k - 4) : 11'd0;
        st.lerr = (k < MIN_LEN) || (k > MAX_LEN);
        if (st.ok && !st.lerr) m_good = m_good + 16'd1;
        else m_bad = m_bad + 16'd1;
        st.g  = m_good;
        st.bd = m_bad;
        sq.push_back(st);
    endtask

    task automatic cyc(input logic s, input logic v, input logic e, input logic [7:0] b);
        sof = s; vld = v; eof = e; byte_in = b;
        @(posedge clk); #1;
        sof = 1'b0; vld = 1'b0; eof = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    // gap < 0 picks 0..2 idle cycles at random after each byte.
    task automatic send_bytes(input int from, input int to, input int gap);
        for (int i = from; i < to; i++) begin
            cyc(i == from, 1'b1, 1'b0, frm[i]);
            if (gap < 0) idle($urandom_range(0, 2));
            else idle(gap);
        end
    endtask

    task automatic send_eof();
        cyc(1'b0, 1'b0, 1'b1, 8'd0);
        idle(2);
    endtask

    task automatic send_frame(input int gap);
        expect_frame(frm.size(), 1'b0);
        send_bytes(0, frm.size(), gap);
        send_eof();
    endtask

    task automatic chk_reset_state();
        chk("rst_sof", 32'(o_sof), 32'd0);
        chk("rst_vld", 32'(o_vld), 32'd0);
        chk("rst_eof", 32'(o_eof), 32'd0);
        chk("rst_status", {28'd0, o_fcs_ok, o_len_err, o_abort, 1'b0}, 32'd0);
        chk("rst_byte", 32'(o_byte), 32'd0);
        chk("rst_len", 32'(o_len), 32'd0);
        chk("rst_good", 32'(good_cnt), 32'd0);
        chk("rst_bad", 32'(bad_cnt), 32'd0);
    endtask

    // Monitor: compare every emitted byte and every end-of-frame against the queues.
    always @(negedge clk) begin
        if (mon_en) begin
            if (o_vld) begin
                if (bq.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_vld actual=%0h expected=none", o_byte);
                end else begin
                    exp_byte_t e;
                    e = bq.pop_front();
                    chk("byte", 32'(o_byte), 32'(e.b));
                    chk("o_sof", 32'(o_sof), 32'(e.s));
                end
            end else if (o_sof) begin
                n_checks++;
                $display("FAIL stray_sof actual=1 expected=0");
            end
            if (o_eof) begin
                if (sq.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_eof actual=1 expected=0");
                end else begin
                    exp_stat_t st;
                    st = sq.pop_front();
                    chk("fcs_ok", 32'(o_fcs_ok), 32'(st.ok));
                    chk("len_err", 32'(o_len_err), 32'(st.lerr));
                    chk("abort", 32'(o_abort), 32'(st.ab));
                    chk("len", 32'(o_len), 32'(st.len));
                    chk("good_cnt", 32'(good_cnt), 32'(st.g));
                    chk("bad_cnt", 32'(bad_cnt), 32'(st.bd));
                end
            end
        end
    end

    initial begin
        string s9;
        int    n;
        int    wait_cyc;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_state();
        rst_n = 1'b1;
        mon_en = 1'b1;
        idle(2);

        // "123456789" with its FCS: good CRC but too short.
        s9 = "123456789";
        frm.delete();
        for (int i = 0; i < 9; i++) frm.push_back(s9[i]);
        frm.push_back(8'h26); frm.push_back(8'h39); frm.push_back(8'hF4); frm.push_back(8'hCB);
        send_frame(0);

        // 64-byte good frame, one byte every 4th cycle; then the same with byte 20 flipped.
        build_good(64);
        send_frame(3);
        frm[20] = frm[20] ^ 8'h10;
        send_frame(3);

        // Tiny and boundary lengths.
        build_rand(3);    send_frame(0);
        build_good(4);    send_frame(1);
        build_good(5);    send_frame(0);
        build_good(63);   send_frame(-1);
        build_good(64);   send_frame(0);
        build_good(1522); send_frame(0);
        build_good(1523); send_frame(0);

        // Stray bytes and eof in IDLE produce nothing.
        cyc(1'b0, 1'b1, 1'b0, 8'hAA);
        cyc(1'b0, 1'b1, 1'b0, 8'h55);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        idle(2);

        // Second eof lands in DONE and is ignored.
        build_good(70);
        expect_frame(70, 1'b0);
        send_bytes(0, 70, 0);
        cyc(1'b0, 1'b0, 1'b1, 8'd0);
        cyc(1'b0, 1'b0, 1'b1, 8'd0);
        idle(2);

        // New sof after 30 bytes aborts the first frame, second frame follows without loss.
        build_good(64);
        expect_frame(30, 1'b1);
        send_bytes(0, 30, -1);
        build_good(64);
        send_frame(-1);

        // Reset after 40 bytes drops the frame and clears the counters.
        build_good(64);
        for (int i = 0; i < 36; i++) bq.push_back('{b: frm[i], s: (i == 0)});
        send_bytes(0, 40, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_reset_state();
        rst_n = 1'b1;
        m_good = 16'd0;
        m_bad = 16'd0;
        cyc(1'b0, 1'b1, 1'b0, 8'h12);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        idle(2);
        build_good(64);
        send_frame(0);

        // Random frames, some with a corrupted bit.
        for (int f = 0; f < 14; f++) begin
            n = $urandom_range(1, 100);
            build_good(n < 4 ? 4 : n);
            if (n < 4) build_rand(n);
            if ($urandom_range(0, 3) == 0) frm[$urandom_range(0, frm.size() - 1)] ^= 8'h01;
            send_frame(-1);
        end

        wait_cyc = 0;
        while ((bq.size() != 0 || sq.size() != 0) && wait_cyc < 50) begin
            idle(1);
            wait_cyc++;
        end
        chk("bytes_left", 32'(bq.size()), 32'd0);
        chk("status_left", 32'(sq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
